// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, screen geometry and helpers for the Pong controller
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  // 11-bit signed so that subtract-then-clamp never wraps
  typedef logic signed [10:0] scoord_t;

  localparam scoord_t TOP_MARGIN      = 11'sd25;
  localparam scoord_t WALL_LEFT       = 11'sd32;
  localparam scoord_t WALL_RIGHT      = 11'sd608;
  localparam scoord_t PADDLE1_X_END   = 11'sd40;
  localparam scoord_t PADDLE2_X       = 11'sd600;
  localparam scoord_t PADDLE_H        = 11'sd72;
  localparam scoord_t BALL_SIZE       = 11'sd8;
  localparam scoord_t BALL_Y_MIN      = 11'sd25;
  localparam scoord_t BALL_Y_MAX      = 11'sd472;
  localparam scoord_t PADDLE_Y_MAX    = 11'sd382;
  localparam scoord_t BALL_X_CENTRE   = 11'sd316;
  localparam scoord_t BALL_Y_CENTRE   = 11'sd248;
  localparam scoord_t PADDLE_Y_CENTRE = 11'sd191;

  // Ball x limits: touching a paddle face, or fully past the paddle column into the wall
  localparam scoord_t BALL_X_HIT1  = PADDLE1_X_END + 11'sd1;
  localparam scoord_t BALL_X_MISS1 = WALL_LEFT;
  localparam scoord_t BALL_X_HIT2  = PADDLE2_X - BALL_SIZE;
  localparam scoord_t BALL_X_MISS2 = WALL_RIGHT - BALL_SIZE + 11'sd1;

  localparam logic [3:0] SPEED_INIT = 4'd2;
  localparam logic [3:0] SPEED_MAX  = 4'd5;

  function automatic scoord_t to_s(input logic [9:0] v);
    return scoord_t'({1'b0, v});
  endfunction

  // Paddle y is in play-field coordinates, ball y in screen coordinates
  function automatic logic overlap(input scoord_t by, input scoord_t py);
    return (by + BALL_SIZE - 11'sd1 >= py + TOP_MARGIN) && (by <= py + TOP_MARGIN + PADDLE_H);
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// rtl/pong_paddle.sv - one paddle: per-frame step up/down with clamping to the play field
module pong_paddle
  import pong_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       up,
  input  logic       dn,
  output logic [9:0] pos
);

  localparam scoord_t STEP_S = scoord_t'(STEP);

  scoord_t up_pos;
  scoord_t dn_pos;

  assign up_pos = to_s(pos) - STEP_S;
  assign dn_pos = to_s(pos) + STEP_S;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= PADDLE_Y_CENTRE[9:0];
    end else if (tick && enable) begin
      if (up && !dn) begin
        pos <= (up_pos < 11'sd0) ? 10'd0 : up_pos[9:0];
      end else if (dn && !up) begin
        pos <= (dn_pos > PADDLE_Y_MAX) ? PADDLE_Y_MAX[9:0] : dn_pos[9:0];
      end
    end
  end

endmodule

// File: rtl/pong_ctrl.sv
// rtl/pong_ctrl.sv - frame-rate Pong game FSM: ball motion, paddle hits, scoring and serve timing
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE        = 7,
  parameter int PADDLE_STEP      = 4,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int SERVE_FRAMES     = 60,
  parameter int POINT_FRAMES     = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_up1,
  input  logic       btn_dn1,
  input  logic       btn_up2,
  input  logic       btn_dn2,
  input  logic       btn_start,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle1_y,
  output logic [9:0] paddle2_y,
  output logic [3:0] ball_speed,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] game_state,
  output logic       winner
);

  state_t     state, state_n;
  logic [9:0] ball_x_n, ball_y_n;
  logic [3:0] speed_n, score1_n, score2_n;
  logic       winner_n, dx_right, dx_right_n, dy_down, dy_down_n;
  logic [7:0] hit_cnt, hit_cnt_n, frame_cnt, frame_cnt_n;

  scoord_t    spd_s, ny_raw, ny, nx;
  logic       bounce, ov1, ov2, hit, point1, point2, paddle_en;
  logic [3:0] score1_inc, score2_inc;

  assign paddle_en = (state == ST_SERVE) || (state == ST_PLAY);

  pong_paddle #(.STEP(PADDLE_STEP)) u_paddle1 (
    .clk(clk), .rst_n(rst_n), .tick(frame_tick), .enable(paddle_en),
    .up(btn_up1), .dn(btn_dn1), .pos(paddle1_y)
  );

  pong_paddle #(.STEP(PADDLE_STEP)) u_paddle2 (
    .clk(clk), .rst_n(rst_n), .tick(frame_tick), .enable(paddle_en),
    .up(btn_up2), .dn(btn_dn2), .pos(paddle2_y)
  );

  assign spd_s  = {7'd0, ball_speed};
  assign ny_raw = dy_down ? to_s(ball_y) + spd_s : to_s(ball_y) - spd_s;
  assign bounce = dy_down ? (ny_raw >= BALL_Y_MAX) : (ny_raw <= BALL_Y_MIN);
  assign ny     = !bounce ? ny_raw : (dy_down ? BALL_Y_MAX : BALL_Y_MIN);
  assign nx     = dx_right ? to_s(ball_x) + spd_s : to_s(ball_x) - spd_s;

  // Overlap uses the post-bounce ball y against the pre-tick paddle positions
  assign ov1    = overlap(ny, to_s(paddle1_y));
  assign ov2    = overlap(ny, to_s(paddle2_y));
  assign hit    = dx_right ? (nx >= BALL_X_HIT2 && ov2) : (nx <= BALL_X_HIT1 && ov1);
  assign point1 = dx_right && !hit && (nx >= BALL_X_MISS2);
  assign point2 = !dx_right && !hit && (nx <= BALL_X_MISS1);

  assign score1_inc = (score1 == 4'd15) ? 4'd15 : score1 + 4'd1;
  assign score2_inc = (score2 == 4'd15) ? 4'd15 : score2 + 4'd1;

  always_comb begin
    state_n     = state;
    ball_x_n    = ball_x;
    ball_y_n    = ball_y;
    speed_n     = ball_speed;
    score1_n    = score1;
    score2_n    = score2;
    winner_n    = winner;
    dx_right_n  = dx_right;
    dy_down_n   = dy_down;
    hit_cnt_n   = hit_cnt;
    frame_cnt_n = frame_cnt;
    case (state)
      ST_IDLE, ST_GAMEOVER: begin
        if (btn_start) begin
          state_n     = ST_SERVE;
          score1_n    = 4'd0;
          score2_n    = 4'd0;
          ball_x_n    = BALL_X_CENTRE[9:0];
          ball_y_n    = BALL_Y_CENTRE[9:0];
          speed_n     = SPEED_INIT;
          dx_right_n  = 1'b1;
          hit_cnt_n   = 8'd0;
          frame_cnt_n = 8'd0;
        end
      end
      ST_SERVE: begin
        if (frame_cnt == 8'(SERVE_FRAMES - 1)) begin
          state_n     = ST_PLAY;
          frame_cnt_n = 8'd0;
        end else begin
          frame_cnt_n = frame_cnt + 8'd1;
        end
      end
      ST_POINT: begin
        // dx still points at the side that conceded, which is the serve direction
        if (frame_cnt == 8'(POINT_FRAMES - 1)) begin
          state_n     = ST_SERVE;
          frame_cnt_n = 8'd0;
          ball_x_n    = BALL_X_CENTRE[9:0];
          ball_y_n    = BALL_Y_CENTRE[9:0];
          speed_n     = SPEED_INIT;
          hit_cnt_n   = 8'd0;
        end else begin
          frame_cnt_n = frame_cnt + 8'd1;
        end
      end
      ST_PLAY: begin
        ball_y_n = ny[9:0];
        if (bounce) dy_down_n = !dy_down;
        if (hit) begin
          ball_x_n   = dx_right ? BALL_X_HIT2[9:0] : BALL_X_HIT1[9:0];
          dx_right_n = !dx_right;
          if (hit_cnt == 8'(HITS_PER_SPEEDUP - 1)) begin
            hit_cnt_n = 8'd0;
            if (ball_speed != SPEED_MAX) speed_n = ball_speed + 4'd1;
          end else begin
            hit_cnt_n = hit_cnt + 8'd1;
          end
        end else if (point1) begin
          ball_x_n = BALL_X_MISS2[9:0];
          score1_n = score1_inc;
          if (score1_inc == 4'(WIN_SCORE)) begin
            state_n  = ST_GAMEOVER;
            winner_n = 1'b0;
          end else begin
            state_n = ST_POINT;
          end
        end else if (point2) begin
          ball_x_n = BALL_X_MISS1[9:0];
          score2_n = score2_inc;
          if (score2_inc == 4'(WIN_SCORE)) begin
            state_n  = ST_GAMEOVER;
            winner_n = 1'b1;
          end else begin
            state_n = ST_POINT;
          end
        end else begin
          ball_x_n = nx[9:0];
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ball_x     <= BALL_X_CENTRE[9:0];
      ball_y     <= BALL_Y_CENTRE[9:0];
      ball_speed <= SPEED_INIT;
      score1     <= 4'd0;
      score2     <= 4'd0;
      winner     <= 1'b0;
      dx_right   <= 1'b1;
      dy_down    <= 1'b1;
      hit_cnt    <= 8'd0;
      frame_cnt  <= 8'd0;
    end else if (frame_tick) begin
      state      <= state_n;
      ball_x     <= ball_x_n;
      ball_y     <= ball_y_n;
      ball_speed <= speed_n;
      score1     <= score1_n;
      score2     <= score2_n;
      winner     <= winner_n;
      dx_right   <= dx_right_n;
      dy_down    <= dy_down_n;
      hit_cnt    <= hit_cnt_n;
      frame_cnt  <= frame_cnt_n;
    end
  end

  assign game_state = state;

endmodule
